// File: rtl/axis_readback_arbiter_pkg.sv
// Shared constants and types for the CPU readback stream arbiter.
package axis_readback_arbiter_pkg;

  // Default number of readback producers sharing the CPU stream.
  localparam int READBACK_NUM_SRC = 4;

  // Position of the per-source enable field inside gpio_in.
  localparam int READBACK_EN_LSB = 0;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    PASS = 1'b1
  } readback_arb_state_t;

  // Width of a source index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_readback_arbiter_if.sv
// AXI-Stream bundle carrying N parallel lanes; the arbiter uses one
// instance with N=NUM_SRC on the slave side and one with N=1 as master.
interface axis_readback_arbiter_if #(
  parameter int N      = 1,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1
);
  logic [N*DATA_W-1:0] tdata;
  logic [N-1:0]        tvalid;
  logic [N-1:0]        tlast;
  logic [N-1:0]        tready;
  logic [ID_W-1:0]     tid;

  modport master (output tdata, output tvalid, output tlast, output tid, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tid, output tready);
endinterface

// File: rtl/axis_readback_arbiter_rr_select.sv
// Circular priority pick: first set request bit at or after rr_ptr.
module axis_readback_arbiter_rr_select #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    sel,
  output logic               any_req
);

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    sel = '0;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_SRC);
      sel = req[idx] ? idx : sel;
    end
    any_req = |req;
  end

endmodule

// File: rtl/axis_readback_arbiter.sv
// Packet-level round-robin arbiter sharing the CPU readback AXI-Stream
// among NUM_SRC producers; a granted source keeps the path until its
// tlast beat is taken, and a one-entry register stage drives the DMA side.
module axis_readback_arbiter
  import axis_readback_arbiter_pkg::*;
#(
  parameter int NUM_SRC = READBACK_NUM_SRC,
  parameter int DATA_W  = 32
) (
  input  logic                    ps_clk,
  input  logic                    rst,
  input  logic [15:0]             gpio_in,
  axis_readback_arbiter_if.slave  s_axis,
  axis_readback_arbiter_if.master m_axis,
  output logic [15:0]             pkt_count
);

  localparam int ID_W = id_width(NUM_SRC);
  localparam logic [ID_W-1:0] LAST_SRC = ID_W'(NUM_SRC - 1);

  readback_arb_state_t state_r;
  logic [ID_W-1:0]     grant_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [DATA_W-1:0]   m_data_r;
  logic [ID_W-1:0]     m_id_r;
  logic                m_last_r;
  logic                m_valid_r;
  logic [15:0]         pkt_count_r;

  logic [NUM_SRC-1:0]  req_s;
  logic [NUM_SRC-1:0]  ready_s;
  logic [ID_W-1:0]     sel_s;
  logic                any_req_s;
  logic [DATA_W-1:0]   src_data_s;
  logic                src_last_s;
  logic                out_free_s;
  logic                src_hs_s;
  logic                m_hs_s;
  logic                unused_gpio;

  // Enables only matter while arbitrating; upper GPIO bits belong to other blocks.
  assign req_s       = s_axis.tvalid & gpio_in[READBACK_EN_LSB +: NUM_SRC];
  assign unused_gpio = ^gpio_in;

  axis_readback_arbiter_rr_select #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_select (
    .req     (req_s),
    .rr_ptr  (rr_ptr_r),
    .sel     (sel_s),
    .any_req (any_req_s)
  );

  // Route the granted lane to the output stage and open only its ready.
  always_comb begin
    src_data_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data_s = (grant_r == ID_W'(i)) ? s_axis.tdata[i*DATA_W +: DATA_W] : src_data_s;
    end
    src_last_s = s_axis.tlast[grant_r];
    out_free_s = !m_valid_r || m_axis.tready[0];
    ready_s    = '0;
    if (state_r == PASS) begin
      ready_s[grant_r] = out_free_s;
    end else begin
      ready_s = '0;
    end
    src_hs_s = (state_r == PASS) && s_axis.tvalid[grant_r] && out_free_s;
    m_hs_s   = m_valid_r && m_axis.tready[0];
  end

  // Arbitration FSM, output register stage and delivered-packet counter.
  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ARB;
      grant_r     <= '0;
      rr_ptr_r    <= '0;
      m_data_r    <= '0;
      m_id_r      <= '0;
      m_last_r    <= 1'b0;
      m_valid_r   <= 1'b0;
      pkt_count_r <= 16'd0;
    end else begin
      if (m_hs_s && m_last_r) begin
        pkt_count_r <= pkt_count_r + 16'd1;
      end
      if (src_hs_s) begin
        m_data_r  <= src_data_s;
        m_last_r  <= src_last_s;
        m_id_r    <= grant_r;
        m_valid_r <= 1'b1;
      end else if (m_hs_s) begin
        m_valid_r <= 1'b0;
      end
      case (state_r)
        ARB: begin
          if (any_req_s) begin
            grant_r <= sel_s;
            state_r <= PASS;
          end
        end
        PASS: begin
          if (src_hs_s && src_last_s) begin
            rr_ptr_r <= (grant_r == LAST_SRC) ? '0 : grant_r + 1'b1;
            state_r  <= ARB;
          end
        end
        default: state_r <= ARB;
      endcase
    end
  end

  assign s_axis.tready = ready_s;
  assign m_axis.tdata  = m_data_r;
  assign m_axis.tid    = m_id_r;
  assign m_axis.tlast  = m_last_r;
  assign m_axis.tvalid = m_valid_r;
  assign pkt_count     = pkt_count_r;

endmodule

// File: tb/tb_axis_readback_arbiter.sv
// Randomised bench for axis_readback_arbiter: per-source packet queues feed
// the DUT, and a packet-level round-robin model predicts the output beats.
module tb_axis_readback_arbiter;
  import axis_readback_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int IDW  = id_width(N);
  localparam int N3   = 3;
  localparam int IDW3 = id_width(N3);

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [IDW-1:0] id;
    logic           l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpio, gpio3, pkt, pkt3;

  always #5 clk = ~clk;

  axis_readback_arbiter_if #(.N(N),  .DATA_W(DW), .ID_W(IDW))  s_if ();
  axis_readback_arbiter_if #(.N(1),  .DATA_W(DW), .ID_W(IDW))  m_if ();
  axis_readback_arbiter_if #(.N(N3), .DATA_W(DW), .ID_W(IDW3)) s3_if ();
  axis_readback_arbiter_if #(.N(1),  .DATA_W(DW), .ID_W(IDW3)) m3_if ();

  axis_readback_arbiter #(.NUM_SRC(N), .DATA_W(DW)) dut (
    .ps_clk(clk), .rst(rst), .gpio_in(gpio), .s_axis(s_if), .m_axis(m_if), .pkt_count(pkt)
  );
  axis_readback_arbiter #(.NUM_SRC(N3), .DATA_W(DW)) dut3 (
    .ps_clk(clk), .rst(rst), .gpio_in(gpio3), .s_axis(s3_if), .m_axis(m3_if), .pkt_count(pkt3)
  );

  int checks = 0;
  int passes = 0;

  // Bench-side source queues and model copies of the same packets.
  logic [DW-1:0] sq_d [N][$];
  logic          sq_l [N][$];
  logic [DW-1:0] md   [N][$];
  logic          ml   [N][$];
  beat_t         exp_q[$];
  int            model_ptr, model_pkts;
  bit            shown [N];
  bit            mid   [N];
  int            hs_cnt[N];
  logic [15:0]   gpio_val;
  int            rdy_pct;
  int            rdy_pat[$];
  bit            gap_en, check_gap, after_last, prev_stall;
  int            idle;
  logic [N-1:0]  forbid;
  beat_t         prev_b;
  int            ptr3;

  task automatic add_pkt(input int s, input int len, input logic [DW-1:0] base);
    for (int b = 0; b < len; b++) begin
      sq_d[s].push_back(base + DW'(b)); sq_l[s].push_back(b == len - 1);
      md[s].push_back(base + DW'(b));   ml[s].push_back(b == len - 1);
    end
  endtask

  task automatic take_pkt(input int s);
    logic l;
    l = 1'b0;
    while (md[s].size() > 0 && !l) begin
      l = ml[s].pop_front();
      exp_q.push_back('{d: md[s].pop_front(), id: IDW'(s), l: l});
    end
    model_ptr = (s + 1) % N;
    model_pkts++;
  endtask

  // Packet-level round robin over backlogged enabled sources.
  task automatic plan(input logic [N-1:0] mask);
    bit found;
    do begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int s;
        s = (model_ptr + k) % N;
        if (!found && mask[s] && md[s].size() > 0) begin
          found = 1'b1;
          take_pkt(s);
        end
      end
    end while (found);
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      sq_d[i].delete(); sq_l[i].delete(); md[i].delete(); ml[i].delete();
      shown[i] = 1'b0; mid[i] = 1'b0; hs_cnt[i] = 0;
    end
    after_last = 1'b0;
  endtask

  task automatic step();
    logic [N*DW-1:0] td;
    logic [N-1:0]    tv, tl, hs;
    beat_t           act, e;
    @(negedge clk);
    gpio = gpio_val;
    if (rdy_pat.size() > 0 && m_if.tvalid[0]) m_if.tready = rdy_pat.pop_front() != 0;
    else m_if.tready = ($urandom_range(0, 99) < rdy_pct);
    td = '0; tv = '0; tl = '0;
    for (int i = 0; i < N; i++) begin
      if (sq_d[i].size() > 0 && (shown[i] || !mid[i] || !gap_en || $urandom_range(0, 2) != 0)) begin
        tv[i] = 1'b1; tl[i] = sq_l[i][0]; td[i*DW +: DW] = sq_d[i][0]; shown[i] = 1'b1;
      end
    end
    s_if.tdata = td; s_if.tvalid = tv; s_if.tlast = tl;
    #1;
    hs  = s_if.tvalid & s_if.tready;
    act = {m_if.tdata, m_if.tid, m_if.tlast[0]};
    checks++;
    if ($countones(s_if.tready) > 1) $display("FAIL ready_onehot: got %b, want at most one bit", s_if.tready);
    else passes++;
    if (forbid != '0) begin
      checks++;
      if ((s_if.tready & forbid) !== '0) $display("FAIL disabled_ready: got %b, want 0 under mask %b", s_if.tready, forbid);
      else passes++;
    end
    if (prev_stall) begin
      checks++;
      if (act !== prev_b || m_if.tvalid[0] !== 1'b1)
        $display("FAIL hold_stable: got %h v=%b, want %h v=1", act, m_if.tvalid, prev_b);
      else passes++;
    end
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL unexpected_beat: got d=%h id=%0d, want no beat", act.d, act.id);
      else begin
        e = exp_q.pop_front();
        if (act !== e) $display("FAIL beat: got d=%h id=%0d l=%b, want d=%h id=%0d l=%b", act.d, act.id, act.l, e.d, e.id, e.l);
        else passes++;
      end
      if (check_gap && after_last) begin
        checks++;
        if (idle != 1) $display("FAIL bubble: got %0d idle cycles, want 1", idle);
        else passes++;
      end
      after_last = m_if.tlast[0];
      idle = 0;
    end else if (!m_if.tvalid[0]) idle++;
    prev_stall = m_if.tvalid[0] && !m_if.tready[0];
    prev_b = act;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        mid[i] = !sq_l[i][0];
        void'(sq_d[i].pop_front()); void'(sq_l[i].pop_front());
        hs_cnt[i]++; shown[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin step(); n++; end
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_timeout: got %0d beats pending, want 0", name, exp_q.size());
    else passes++;
  endtask

  task automatic check_pkt(input string name);
    @(negedge clk);
    checks++;
    if (pkt !== 16'(model_pkts)) $display("FAIL %s_pkt_count: got %0d, want %0d", name, pkt, model_pkts);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b0; gpio = 16'h0; gpio_val = 16'h0; gpio3 = 16'h0007;
    s_if.tdata = '0; s_if.tvalid = '0; s_if.tlast = '0; s_if.tid = '0; m_if.tready = 1'b0;
    s3_if.tdata = '0; s3_if.tvalid = '0; s3_if.tlast = '0; s3_if.tid = '0; m3_if.tready = 1'b0;
    model_ptr = 0; model_pkts = 0; ptr3 = 0; forbid = '0; prev_stall = 1'b0; idle = 0;
    clear_srcs();
    repeat (3) @(negedge clk);
    checks++;
    if ({m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tid, pkt, s_if.tready} !== '0)
      $display("FAIL reset_outputs: got v=%b l=%b d=%h id=%0d pkt=%0d rdy=%b, want all 0",
               m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tid, pkt, s_if.tready);
    else passes++;
    checks++;
    if ({m3_if.tvalid, pkt3, s3_if.tready} !== '0) $display("FAIL reset_outputs3: got v=%b pkt=%0d rdy=%b, want 0", m3_if.tvalid, pkt3, s3_if.tready);
    else passes++;
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (s_if.tready !== '0 || m_if.tvalid[0] !== 1'b0) $display("FAIL idle_after_reset: got rdy=%b v=%b, want 0", s_if.tready, m_if.tvalid);
    else passes++;
  endtask

  task automatic test_round_robin();
    clear_srcs();
    gpio_val = 16'h000F; rdy_pct = 100; gap_en = 1'b0; check_gap = 1'b1;
    for (int i = 0; i < N; i++) add_pkt(i, 4, DW'(32'h1000 * i));
    plan(4'hF);
    run(200, "round_robin");
    check_gap = 1'b0;
    check_pkt("round_robin");
  endtask

  task automatic test_enable_mask();
    clear_srcs();
    gpio_val = 16'h0005; forbid = 4'hA; rdy_pct = 100;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) add_pkt(i, 3, DW'(32'h2000 + 32'h100 * i + 32'h10 * p));
    plan(4'h5);
    run(200, "enable_mask");
    check_pkt("enable_mask");
    clear_srcs();
    repeat (3) step();
    forbid = '0;
  endtask

  task automatic test_backpressure();
    clear_srcs();
    gpio_val = 16'h0002; rdy_pct = 100;
    add_pkt(1, 3, 32'hA);
    rdy_pat = '{1, 0, 0, 1};
    plan(4'h2);
    run(100, "backpressure");
    repeat (4) step();
    check_pkt("backpressure");
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    for (int r = 0; r < 8; r++) begin
      clear_srcs();
      mask = N'($urandom_range(1, (1 << N) - 1));
      gpio_val = 16'(mask); forbid = ~mask; rdy_pct = 70; gap_en = 1'b1;
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 4), $urandom);
      end
      plan(mask);
      run(600, "random");
      check_pkt("random");
    end
    clear_srcs();
    forbid = '0; gap_en = 1'b0; rdy_pct = 100;
    repeat (2) step();
  endtask

  task automatic test_enable_clear();
    int n;
    clear_srcs();
    gpio_val = 16'h0002; rdy_pct = 100;
    add_pkt(1, 5, 32'h5000);
    add_pkt(1, 5, 32'h5100);
    take_pkt(1);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step(); n++;
      if (hs_cnt[1] == 2) gpio_val = 16'h0000;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL enable_clear_timeout: got %0d beats pending, want 0", exp_q.size());
    else passes++;
    forbid = 4'h2;
    repeat (20) step();
    check_pkt("enable_clear");
    clear_srcs();
    forbid = '0;
  endtask

  // Single-beat packets on the three-source instance; each source offers one packet.
  task automatic run3(input logic [N3-1:0] mask);
    int            e3[$];
    int            last, n, e;
    logic [N3-1:0] pend, hs;
    logic [N3*DW-1:0] td;
    last = -1;
    for (int k = 0; k < N3; k++) if (mask[(ptr3 + k) % N3]) begin e3.push_back((ptr3 + k) % N3); last = (ptr3 + k) % N3; end
    if (last >= 0) ptr3 = (last + 1) % N3;
    pend = mask; n = 0;
    while (e3.size() > 0 && n < 50) begin
      @(negedge clk);
      td = '0;
      for (int i = 0; i < N3; i++) td[i*DW +: DW] = DW'(32'h300 + i);
      m3_if.tready = 1'b1; s3_if.tdata = td; s3_if.tvalid = pend; s3_if.tlast = pend;
      #1;
      hs = s3_if.tvalid & s3_if.tready;
      if (m3_if.tvalid[0]) begin
        e = e3.pop_front();
        checks++;
        if (m3_if.tid !== IDW3'(e) || m3_if.tdata !== DW'(32'h300 + e) || m3_if.tlast[0] !== 1'b1)
          $display("FAIL wrap3_beat: got id=%0d d=%h l=%b, want id=%0d d=%h l=1", m3_if.tid, m3_if.tdata, m3_if.tlast, e, 32'h300 + e);
        else passes++;
      end
      @(posedge clk);
      pend = pend & ~hs;
      n++;
    end
    checks++;
    if (e3.size() != 0) $display("FAIL wrap3_timeout: got %0d pending, want 0", e3.size());
    else passes++;
  endtask

  task automatic test_wrap_3src();
    repeat (3) run3(3'b100);
    run3(3'b101);
    @(negedge clk);
    s3_if.tvalid = '0;
    checks++;
    if (pkt3 !== 16'd5) $display("FAIL wrap3_pkt_count: got %0d, want 5", pkt3);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_srcs();
    gpio_val = 16'h0008; rdy_pct = 100; gap_en = 1'b0;
    add_pkt(3, 8, 32'h7000);
    plan(4'h8);
    n = 0;
    while (exp_q.size() > 5 && n < 100) begin step(); n++; end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (m_if.tvalid[0] !== 1'b0 || pkt !== 16'd0 || s_if.tready !== '0)
      $display("FAIL reset_mid: got v=%b pkt=%0d rdy=%b, want 0 0 0", m_if.tvalid, pkt, s_if.tready);
    else passes++;
    clear_srcs();
    exp_q.delete();
    model_ptr = 0; model_pkts = 0; prev_stall = 1'b0;
    add_pkt(0, 2, 32'h8000);
    add_pkt(3, 2, 32'h8300);
    gpio_val = 16'h0009;
    @(negedge clk);
    gpio = gpio_val; s_if.tvalid = '0;
    @(negedge clk);
    rst = 1'b1;
    plan(4'h9);
    run(100, "reset_mid");
    check_pkt("reset_mid");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_enable_mask();
    test_backpressure();
    test_random();
    test_enable_clear();
    test_wrap_3src();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
